// File: rtl/scoring_matrix_ctrl_if.sv
// Handshake and matrix-write bundle between producer, sequencer and consumer.
// round_count is only meaningful when SCORE_CTRL_STATS_EN is defined.
interface scoring_matrix_ctrl_if #(
    parameter int N       = 10,
    parameter int ROUND_W = 8
) ();
    logic                   start;
    logic                   abort;
    logic [N-1:0][1:0]      col_data;
    logic                   col_valid;
    logic                   col_ready;
    logic [N-1:0][1:0]      mat_data_in;
    logic [N-1:0]           mat_data_valid;
    logic                   mat_done;
    logic [$clog2(N)-1:0]   col_idx;
    logic                   busy;
    logic                   result_valid;
    logic                   result_ack;
    logic                   error;
    logic [ROUND_W-1:0]     round_count;

    modport master (
        output start, abort, col_data, col_valid, mat_done, result_ack,
        input  col_ready, mat_data_in, mat_data_valid, col_idx, busy,
        input  result_valid, error, round_count
    );

    modport slave (
        input  start, abort, col_data, col_valid, mat_done, result_ack,
        output col_ready, mat_data_in, mat_data_valid, col_idx, busy,
        output result_valid, error, round_count
    );
endinterface

// File: rtl/scoring_matrix_ctrl.sv
// Column sequencer in front of scoring_matrix: fill, wait for done, hand off.
// Optional round counter enabled by defining SCORE_CTRL_STATS_EN.
module scoring_matrix_ctrl #(
    parameter int N            = 10,
    parameter int DONE_TIMEOUT = 4,
    parameter int ROUND_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    scoring_matrix_ctrl_if.slave  bus
);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, FILL, WAIT_DONE, RESULT} state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     idx;
    logic [CW-1:0]     cnt;
    logic [N-1:0][1:0] data_q;
    logic [N-1:0]      valid_q;
    logic              err_q;
    logic              accept, last, timeout;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        accept    = (state == FILL) && bus.col_valid && !bus.abort;
        last      = (idx == IW'(N - 1));
        timeout   = (state == WAIT_DONE) && !bus.mat_done &&
                    (cnt == CW'(DONE_TIMEOUT - 1));
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:      if (bus.start) state_nxt = FILL;
                FILL:      if (accept && last) state_nxt = WAIT_DONE;
                WAIT_DONE: begin
                    if (bus.mat_done)  state_nxt = RESULT;
                    else if (timeout)  state_nxt = IDLE;
                end
                RESULT:    if (bus.result_ack) state_nxt = IDLE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    // The write pulse is rebuilt every cycle, so it can never outlive its accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            cnt     <= '0;
            data_q  <= '0;
            valid_q <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= '0;
            cnt     <= (state == WAIT_DONE) ? cnt + 1'b1 : '0;
            if (bus.abort) begin
                idx <= '0;
            end else begin
                if (state == IDLE && bus.start) begin
                    idx   <= '0;
                    err_q <= 1'b0;
                end
                if (accept) begin
                    data_q  <= bus.col_data;
                    valid_q <= {{(N-1){1'b0}}, 1'b1} << idx;
                    idx     <= last ? '0 : idx + 1'b1;
                end
                if (timeout) err_q <= 1'b1;
            end
        end
    end

`ifdef SCORE_CTRL_STATS_EN
    logic [ROUND_W-1:0] rounds;

    always_ff @(posedge clk) begin
        if (rst)
            rounds <= '0;
        else if (state == RESULT && bus.result_ack && !bus.abort)
            rounds <= rounds + 1'b1;
    end

    assign bus.round_count = rounds;
`else
    assign bus.round_count = '0;
`endif

    assign bus.col_ready      = (state == FILL) && !bus.abort;
    assign bus.busy           = (state == FILL) || (state == WAIT_DONE);
    assign bus.result_valid   = (state == RESULT);
    assign bus.col_idx        = idx;
    assign bus.mat_data_in    = data_q;
    assign bus.mat_data_valid = valid_q;
    assign bus.error          = err_q;
endmodule

// File: tb/tb_scoring_matrix_ctrl.sv
// Directed bench for scoring_matrix_ctrl with a round-level reference model
// and a small stand-in for scoring_matrix that raises done after a full fill.
module tb_scoring_matrix_ctrl;
    localparam int N  = 10;
    localparam int TO = 4;
    localparam int RW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scoring_matrix_ctrl_if #(.N(N), .ROUND_W(RW)) bus ();

    scoring_matrix_ctrl #(.N(N), .DONE_TIMEOUT(TO), .ROUND_W(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0][1:0] colval(input int c, input int seed);
        logic [N-1:0][1:0] v;
        for (int r = 0; r < N; r++) v[r] = 2'((10 * c + r + 7 * seed) & 3);
        return v;
    endfunction

    // Matrix stand-in: done rises once columns 0..N-1 were all written in order.
    logic [N-1:0][1:0] mem [N];
    logic [N-1:0]      wmask = '0;
    logic              done_r = 1'b0;
    logic              kill = 1'b0;
    assign bus.mat_done = done_r & ~kill;

    always @(posedge clk) begin
        for (int j = 0; j < N; j++) begin
            if (bus.mat_data_valid[j]) begin
                mem[j] <= bus.mat_data_in;
                if (j == 0) begin
                    wmask  <= N'(1);
                    done_r <= 1'b0;
                end else begin
                    wmask[j] <= 1'b1;
                    if (j == N - 1 && &wmask[N-2:0]) done_r <= 1'b1;
                end
            end
        end
    end

    // Reference model: 0 idle, 1 collecting, 2 awaiting done, 3 result held.
    int                m_phase, m_got, m_wait, m_pulse, m_rounds;
    bit                m_err;
    logic [N-1:0][1:0] m_data;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_got = 0; m_wait = 0; m_pulse = -1;
            m_rounds = 0; m_err = 0; m_data = '0;
        end else begin
            m_pulse = -1;
            if (bus.abort) begin
                if (m_phase != 0) begin
                    m_phase = 0;
                    m_got   = 0;
                end
            end else if (m_phase == 0) begin
                if (bus.start) begin
                    m_phase = 1; m_got = 0; m_err = 0;
                end
            end else if (m_phase == 1) begin
                if (bus.col_valid) begin
                    m_pulse = m_got;
                    m_data  = bus.col_data;
                    m_got++;
                    if (m_got == N) begin
                        m_got = 0; m_phase = 2; m_wait = 0;
                    end
                end
            end else if (m_phase == 2) begin
                if (bus.mat_done) begin
                    m_phase = 3;
                end else begin
                    m_wait++;
                    if (m_wait == TO) begin
                        m_err = 1; m_phase = 0;
                    end
                end
            end else begin
                if (bus.result_ack) begin
                    m_phase = 0;
                    m_rounds++;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] ev;
        if (chk_on) begin
            ev = '0;
            if (m_pulse >= 0) ev[m_pulse] = 1'b1;
            check("col_ready", 64'(bus.col_ready), 64'(m_phase == 1 && !bus.abort));
            check("busy", 64'(bus.busy), 64'(m_phase == 1 || m_phase == 2));
            check("result_valid", 64'(bus.result_valid), 64'(m_phase == 3));
            check("col_idx", 64'(bus.col_idx), 64'(m_got));
            check("mat_data_valid", 64'(bus.mat_data_valid), 64'(ev));
            check("mat_data_in", 64'(bus.mat_data_in), 64'(m_data));
            check("error", 64'(bus.error), 64'(m_err));
`ifdef SCORE_CTRL_STATS_EN
            check("round_count", 64'(bus.round_count), 64'(RW'(m_rounds)));
`else
            check("round_count", 64'(bus.round_count), 64'(0));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_round();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("busy_after_start", 64'(bus.busy), 64'(1));
    endtask

    task automatic feed(input int seed, input int ncols, input bit bubble);
        int c = 0;
        int cyc = 0;
        while (c < ncols && cyc < 100) begin
            bus.col_valid = !bubble || (cyc % 2 == 0);
            bus.col_data  = colval(c, seed);
            tick();
            if (bus.col_valid) begin
                check("mdv_pulse", 64'(bus.mat_data_valid), 64'(1) << c);
                check("idx_after_accept", 64'(bus.col_idx), 64'((c + 1) % N));
                c++;
            end else begin
                check("mdv_bubble", 64'(bus.mat_data_valid), 64'(0));
            end
            cyc++;
        end
        bus.col_valid = 1'b0;
    endtask

    task automatic expect_result_at_k2();
        tick();
        check("rv_k1", 64'(bus.result_valid), 64'(0));
        tick();
        check("rv_k2", 64'(bus.result_valid), 64'(1));
    endtask

    task automatic ack_result();
        bus.result_ack = 1'b1;
        tick();
        bus.result_ack = 1'b0;
        check("rv_after_ack", 64'(bus.result_valid), 64'(0));
    endtask

    task automatic check_matrix(input int seed);
        for (int c = 0; c < N; c++)
            check("matrix_col", 64'(mem[c]), 64'(colval(c, seed)));
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.start = 0; bus.abort = 0; bus.col_valid = 0;
        bus.col_data = '0; bus.result_ack = 0;
        tick();
        chk_on = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_ready", 64'(bus.col_ready), 64'(0));
        check("rst_mdv", 64'(bus.mat_data_valid), 64'(0));
        check("rst_round", 64'(bus.round_count), 64'(0));

        // Back-to-back full round.
        begin_round();
        feed(0, N, 0);
        expect_result_at_k2();
        check_matrix(0);
        ack_result();
        check("idle_after_ack", 64'(bus.busy), 64'(0));
`ifdef SCORE_CTRL_STATS_EN
        check("round_one", 64'(bus.round_count), 64'(1));
`endif

        // Upstream bubbles.
        begin_round();
        feed(1, N, 1);
        n = 0;
        while (!bus.result_valid && n < 20) begin
            tick();
            n++;
        end
        check("bubble_result", 64'(bus.result_valid), 64'(1));
        check_matrix(1);
        ack_result();

        // Abort mid-fill, column offered alongside abort must be dropped.
        begin_round();
        feed(2, 6, 0);
        bus.abort = 1'b1;
        bus.col_valid = 1'b1;
        bus.col_data = colval(6, 2);
        tick();
        bus.abort = 1'b0;
        bus.col_valid = 1'b0;
        check("abort_idx", 64'(bus.col_idx), 64'(0));
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_mdv", 64'(bus.mat_data_valid), 64'(0));
        repeat (3) tick();
        check("abort_no_result", 64'(bus.result_valid), 64'(0));
        begin_round();
        feed(3, N, 0);
        expect_result_at_k2();
        check_matrix(3);
        ack_result();

        // Done never arrives: error exactly TO cycles into WAIT_DONE.
        kill = 1'b1;
        begin_round();
        feed(4, N, 0);
        for (int i = 1; i <= TO; i++) begin
            tick();
            check("timeout_err", 64'(bus.error), 64'(i == TO));
        end
        check("timeout_idle", 64'(bus.busy), 64'(0));
        kill = 1'b0;
        begin_round();
        check("err_cleared", 64'(bus.error), 64'(0));

        // Stale done during fill, ack on first RESULT cycle, start ignored.
        feed(5, N, 0);
        expect_result_at_k2();
        bus.result_ack = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.result_ack = 1'b0;
        bus.start = 1'b0;
        check("one_cycle_rv", 64'(bus.result_valid), 64'(0));
        check("start_in_result", 64'(bus.busy), 64'(0));

        // Abort beats start in IDLE.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("abort_beats_start", 64'(bus.busy), 64'(0));

        // Reset mid-round.
        begin_round();
        feed(6, 3, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_idx", 64'(bus.col_idx), 64'(0));
        check("rst_mid_busy", 64'(bus.busy), 64'(0));
        check("rst_mid_round", 64'(bus.round_count), 64'(0));
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
